// File: rtl/fpadd_arbiter.sv
// Round-robin front end that shares one FP16 adder among NUM_REQ requesters and
// returns results through a credit-limited response FIFO. Optional: FPADD_ARBITER_SUB_EN.
module fpadd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADD_LAT    = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
`ifdef FPADD_ARBITER_SUB_EN
  input  logic [NUM_REQ-1:0]    req_sub,
`endif
  output logic                  add_valid,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  input  logic [15:0]           add_res,
  input  logic                  add_ovf,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [15:0]           rsp_res,
  output logic                  rsp_ovf,
  output logic                  busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = IDW + 17;

  logic [15:0] a_vec [NUM_REQ];
  logic [15:0] b_vec [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_vec[gi] = req_a[16*gi +: 16];
      assign b_vec[gi] = req_b[16*gi +: 16];
    end
  endgenerate

  logic [IDW-1:0]     rr_ptr_reg;
  logic [CW-1:0]      cnt_reg;
  logic [CW-1:0]      cnt_next;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     gidx;
  logic [IDW-1:0]     scan_idx;
  logic               grant_any;
  logic               pop;

  // First valid requester at or after the pointer wins; no credit means no grant.
  always_comb begin
    grant     = '0;
    gidx      = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr_reg) + k) % NUM_REQ);
      if (!grant_any && req_valid[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        gidx            = scan_idx;
        grant_any       = 1'b1;
      end
    end
    if (!rst_n || cnt_reg == CW'(FIFO_DEPTH)) begin
      grant     = '0;
      grant_any = 1'b0;
    end
  end

  assign req_ready = grant;
  assign busy      = (cnt_reg != '0);

  always_comb begin
    cnt_next = cnt_reg;
    case ({grant_any, pop})
      2'b10:   cnt_next = cnt_reg + 1'b1;
      2'b01:   cnt_next = cnt_reg - 1'b1;
      default: cnt_next = cnt_reg;
    endcase
  end

  logic [15:0] b_issue;
`ifdef FPADD_ARBITER_SUB_EN
  assign b_issue = b_vec[gidx] ^ {req_sub[gidx], 15'b0};
`else
  assign b_issue = b_vec[gidx];
`endif

  logic           add_valid_reg;
  logic [15:0]    add_a_reg;
  logic [15:0]    add_b_reg;
  logic [IDW-1:0] issue_id_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_valid_reg <= 1'b0;
      add_a_reg     <= '0;
      add_b_reg     <= '0;
      issue_id_reg  <= '0;
      rr_ptr_reg    <= '0;
      cnt_reg       <= '0;
    end else begin
      add_valid_reg <= grant_any;
      cnt_reg       <= cnt_next;
      if (grant_any) begin
        add_a_reg    <= a_vec[gidx];
        add_b_reg    <= b_issue;
        issue_id_reg <= gidx;
        rr_ptr_reg   <= (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end

  assign add_valid = add_valid_reg;
  assign add_a     = add_a_reg;
  assign add_b     = add_b_reg;

  // Tag pipeline: stage ADD_LAT-1 lines up with the adder result for that issue.
  generate
    for (genvar gi = 0; gi < ADD_LAT; gi++) begin : g_tag
      logic           v_reg;
      logic [IDW-1:0] id_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v_reg  <= 1'b0;
            id_reg <= '0;
          end else begin
            v_reg  <= add_valid_reg;
            id_reg <= issue_id_reg;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v_reg  <= 1'b0;
            id_reg <= '0;
          end else begin
            v_reg  <= g_tag[gi-1].v_reg;
            id_reg <= g_tag[gi-1].id_reg;
          end
        end
      end
    end
  endgenerate

  logic          push;
  logic [EW-1:0] push_data;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] rd_ptr_next;
  logic [CW-1:0] fifo_cnt_reg;
  logic [CW-1:0] fifo_cnt_next;
  logic [CW-1:0] fifo_rem;
  logic [EW-1:0] head_next;
  logic          rsp_valid_reg;
  logic [IDW-1:0] rsp_id_reg;
  logic [15:0]   rsp_res_reg;
  logic          rsp_ovf_reg;

  assign push      = g_tag[ADD_LAT-1].v_reg;
  assign push_data = {g_tag[ADD_LAT-1].id_reg, add_res, add_ovf};
  assign pop       = rsp_valid_reg & rsp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Next head bypasses the array when the FIFO drains to empty in the same cycle.
  always_comb begin
    fifo_rem      = fifo_cnt_reg - CW'(pop);
    fifo_cnt_next = fifo_rem + CW'(push);
    rd_ptr_next   = rd_ptr_reg + PW'(pop);
    head_next     = (fifo_rem == '0) ? push_data : mem[rd_ptr_next];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      fifo_cnt_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_res_reg   <= '0;
      rsp_ovf_reg   <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_reg + PW'(push);
      rd_ptr_reg    <= rd_ptr_next;
      fifo_cnt_reg  <= fifo_cnt_next;
      rsp_valid_reg <= (fifo_cnt_next != '0);
      if (fifo_cnt_next != '0) begin
        {rsp_id_reg, rsp_res_reg, rsp_ovf_reg} <= head_next;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_res   = rsp_res_reg;
  assign rsp_ovf   = rsp_ovf_reg;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Directed bench for fpadd_arbiter: vector table plus multi-cycle sequences for
// round-robin order, credit stall, FIFO wrap, mid-flight reset and optional subtract.
module tb_fpadd_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int ADD_LAT    = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int IDW        = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
`ifdef FPADD_ARBITER_SUB_EN
  logic [NUM_REQ-1:0]    req_sub;
`endif
  logic                  add_valid;
  logic [15:0]           add_a;
  logic [15:0]           add_b;
  logic [15:0]           add_res;
  logic                  add_ovf;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [15:0]           rsp_res;
  logic                  rsp_ovf;
  logic                  busy;

  fpadd_arbiter #(.NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
`ifdef FPADD_ARBITER_SUB_EN
    .req_sub(req_sub),
`endif
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
    .add_res(add_res), .add_ovf(add_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in adder: only data routing matters, so the result is a simple tag.
  function automatic logic [15:0] model_res(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h3C00 && b == 16'h4000) return 16'h4200;
    return a ^ b;
  endfunction

  function automatic logic model_ovf(input logic [15:0] a, input logic [15:0] b);
    return (a[14:10] == 5'h1F) || (b[14:10] == 5'h1F);
  endfunction

  logic [15:0] pipe_r [ADD_LAT+1];
  logic        pipe_o [ADD_LAT+1];

  initial begin
    for (int k = 0; k <= ADD_LAT; k++) begin
      pipe_r[k] = 16'h0;
      pipe_o[k] = 1'b0;
    end
    add_res = 16'h0;
    add_ovf = 1'b0;
  end

  // Result for an add_valid in cycle C is presented throughout cycle C+ADD_LAT.
  always @(negedge clk) begin
    for (int k = ADD_LAT; k > 0; k--) begin
      pipe_r[k] = pipe_r[k-1];
      pipe_o[k] = pipe_o[k-1];
    end
    pipe_r[0] = add_valid ? model_res(add_a, add_b) : 16'hDEAD;
    pipe_o[0] = add_valid ? model_ovf(add_a, add_b) : 1'b1;
    add_res   = pipe_r[ADD_LAT];
    add_ovf   = pipe_o[ADD_LAT];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    tick();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(0));
    chk({tag, "_add_valid"}, 32'(add_valid), 32'(0));
    chk({tag, "_add_a"},     32'(add_a),     32'(0));
    chk({tag, "_add_b"},     32'(add_b),     32'(0));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({tag, "_rsp_id"},    32'(rsp_id),    32'(0));
    chk({tag, "_rsp_res"},   32'(rsp_res),   32'(0));
    chk({tag, "_rsp_ovf"},   32'(rsp_ovf),   32'(0));
    chk({tag, "_busy"},      32'(busy),      32'(0));
  endtask

  typedef struct {
    int          rid;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
  } vec_t;

  vec_t        vecs [4];
  int          lat;
  int          ngr;
  int          npop;
  int          g;
  int          vcnt;
  int          exp_id_q  [$];
  logic [15:0] exp_res_q [$];
  logic        exp_ovf_q [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{rid: 0, a: 16'h3C00, b: 16'h4000, res: 16'h4200, ovf: 1'b0};
    vecs[1] = '{rid: 2, a: 16'h1234, b: 16'h00FF, res: 16'h12CB, ovf: 1'b0};
    vecs[2] = '{rid: 3, a: 16'h7C00, b: 16'h3C00, res: 16'h4000, ovf: 1'b1};
    vecs[3] = '{rid: 1, a: 16'h8001, b: 16'h0001, res: 16'h8000, ovf: 1'b0};

    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = 64'h1111_2222_3333_4444;
    req_b     = 64'h5555_6666_7777_8888;
    rsp_ready = 1'b0;
`ifdef FPADD_ARBITER_SUB_EN
    req_sub   = '0;
`endif
    repeat (2) tick();
    #1 chk_idle("por");
    req_valid = '0;
    tick();
    rst_n = 1'b1;

    // Single-request vectors: grant, issue, latency and response payload.
    for (int v = 0; v < 4; v++) begin
      tick();
      rsp_ready = 1'b1;
      req_a[16*vecs[v].rid +: 16] = vecs[v].a;
      req_b[16*vecs[v].rid +: 16] = vecs[v].b;
      req_valid = 4'(1 << vecs[v].rid);
      #1 chk("vec_grant", 32'(req_ready), 32'(1 << vecs[v].rid));
      tick();
      req_valid = '0;
      #1;
      chk("vec_add_valid", 32'(add_valid), 32'(1));
      chk("vec_add_a", 32'(add_a), 32'(vecs[v].a));
      chk("vec_add_b", 32'(add_b), 32'(vecs[v].b));
      chk("vec_busy", 32'(busy), 32'(1));
      lat = 1;
      while (lat < 20 && !rsp_valid) begin
        tick();
        #1;
        lat++;
        if (lat == 2) chk("vec_add_valid_drop", 32'(add_valid), 32'(0));
      end
      chk("vec_latency", 32'(lat), 32'(ADD_LAT + 2));
      chk("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].rid));
      chk("vec_rsp_res", 32'(rsp_res), 32'(vecs[v].res));
      chk("vec_rsp_ovf", 32'(rsp_ovf), 32'(vecs[v].ovf));
      tick();
      #1;
      chk("vec_rsp_popped", 32'(rsp_valid), 32'(0));
      chk("vec_busy_clear", 32'(busy), 32'(0));
    end

    // All requesters valid: round-robin order and 20 ordered responses across wrap.
    apply_reset();
    rsp_ready = 1'b1;
    ngr  = 0;
    npop = 0;
    for (int c = 0; c < 400 && npop < 20; c++) begin
      tick();
      for (int i = 0; i < NUM_REQ; i++) begin
        req_a[16*i +: 16] = 16'h1000 + 16'(ngr * 16 + i);
        req_b[16*i +: 16] = 16'h0100 + 16'(i * 3);
      end
      req_valid = (ngr < 20) ? 4'hF : 4'h0;
      #1;
      if (rsp_valid) begin
        chk("rr_q_nonempty", 32'(exp_id_q.size() != 0), 32'(1));
        if (exp_id_q.size() != 0) begin
          chk("rr_rsp_id", 32'(rsp_id), 32'(exp_id_q.pop_front()));
          chk("rr_rsp_res", 32'(rsp_res), 32'(exp_res_q.pop_front()));
          chk("rr_rsp_ovf", 32'(rsp_ovf), 32'(exp_ovf_q.pop_front()));
        end
        npop++;
      end
      if (req_ready != '0) begin
        g = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_ready == 4'(1 << i)) g = i;
        end
        chk("rr_order", 32'(g), 32'(ngr % NUM_REQ));
        if (g >= 0) begin
          exp_id_q.push_back(g);
          exp_res_q.push_back(model_res(req_a[16*g +: 16], req_b[16*g +: 16]));
          exp_ovf_q.push_back(model_ovf(req_a[16*g +: 16], req_b[16*g +: 16]));
        end
        ngr++;
      end
    end
    chk("rr_grants", 32'(ngr), 32'(20));
    chk("rr_pops", 32'(npop), 32'(20));
    tick();
    #1 chk("rr_busy_end", 32'(busy), 32'(0));

    // Credit stall: no pops allows exactly FIFO_DEPTH grants.
    apply_reset();
    ngr = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      req_valid = 4'hF;
      #1;
      if (req_ready != '0) ngr++;
    end
    chk("stall_grants", 32'(ngr), 32'(FIFO_DEPTH));
    chk("stall_ready", 32'(req_ready), 32'(0));
    chk("stall_busy", 32'(busy), 32'(1));
    tick();
    rsp_ready = 1'b1;
    #1;
    chk("stall_pop_valid", 32'(rsp_valid), 32'(1));
    chk("stall_pop_id", 32'(rsp_id), 32'(0));
    chk("stall_ready_pop_cycle", 32'(req_ready), 32'(0));
    tick();
    rsp_ready = 1'b0;
    #1 chk("stall_regrant", 32'(req_ready), 32'(4'b0001));
    tick();
    #1 chk("stall_full_again", 32'(req_ready), 32'(0));
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && busy; c++) tick();
    #1 chk("stall_drained", 32'(busy), 32'(0));

    // Reset with two operations in flight.
    apply_reset();
    rsp_ready = 1'b1;
    req_a = 64'hAAAA_BBBB_CCCC_DDDD;
    req_b = 64'h0101_0202_0303_0404;
    tick();
    req_valid = 4'b0110;
    #1 chk("rst_grant1", 32'(req_ready), 32'(4'b0010));
    tick();
    #1 chk("rst_grant2", 32'(req_ready), 32'(4'b0100));
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    #1 chk_idle("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      #1;
      if (rsp_valid || busy) vcnt++;
    end
    chk("rst_no_late_rsp", 32'(vcnt), 32'(0));
    tick();
    req_valid = 4'hF;
    #1 chk("rst_next_grant", 32'(req_ready), 32'(4'b0001));
    tick();
    req_valid = '0;
    for (int c = 0; c < 40 && busy; c++) tick();

`ifdef FPADD_ARBITER_SUB_EN
    // Subtract request flips the sign of operand B.
    apply_reset();
    rsp_ready = 1'b1;
    tick();
    req_a[16 +: 16] = 16'h4200;
    req_b[16 +: 16] = 16'h3C00;
    req_sub   = 4'b0010;
    req_valid = 4'b0010;
    #1 chk("sub_grant", 32'(req_ready), 32'(4'b0010));
    tick();
    req_valid = '0;
    req_sub   = '0;
    #1;
    chk("sub_add_valid", 32'(add_valid), 32'(1));
    chk("sub_add_a", 32'(add_a), 32'(16'h4200));
    chk("sub_add_b", 32'(add_b), 32'(16'hBC00));
    for (int c = 0; c < 40 && busy; c++) tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpadd_arbiter.md
FPADD_ARBITER -- requirements
Module: fpadd_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (legal 2..8).
REQ-002 The block SHALL have parameter ADD_LAT, default 3, giving the adder latency in cycles from add_valid to add_res valid (legal 1..8).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of response FIFO entries (power of 2, legal 2..16).
REQ-004 Ports SHALL be, one per line, as follows, with IDW = clog2(NUM_REQ).
 clk  in  1  single clock, rising edge
 rst_n  in  1  reset, asynchronous, active-low
 req_valid  in  NUM_REQ  per-requester operation valid
 req_ready  out  NUM_REQ  per-requester grant, one-hot or zero
 req_a  in  16*NUM_REQ  FP16 operand A, requester i at bits [16i+15:16i]
 req_b  in  16*NUM_REQ  FP16 operand B, same packing
 add_valid  out  1  issue strobe to the shared FP16 adder
 add_a  out  16  operand A to the adder
 add_b  out  16  operand B to the adder
 add_res  in  16  adder result
 add_ovf  in  1  adder overflow/special flag
 rsp_valid  out  1  response available
 rsp_ready  in  1  response accepted
 rsp_id  out  IDW  index of the requester that owns the response
 rsp_res  out  16  result
 rsp_ovf  out  1  overflow flag
 busy  out  1  one or more operations are outstanding

Function
REQ-005 A request handshake SHALL occur when req_valid[i] and req_ready[i] are both 1; at most one grant SHALL occur per cycle.
REQ-006 Arbitration SHALL be round-robin; the search SHALL start at (last granted index + 1) mod NUM_REQ; after reset the search SHALL start at index 0.
REQ-007 The credit counter cnt (0..FIFO_DEPTH) SHALL increment on a grant and decrement on a FIFO pop; a simultaneous grant and pop SHALL leave cnt unchanged.
REQ-008 The block SHALL drive req_ready all-zero when cnt == FIFO_DEPTH; a pop SHALL release its credit in the next cycle, with no combinational path from rsp_ready to req_ready.
REQ-009 After a handshake in cycle N, the block SHALL drive add_valid=1 for exactly one cycle in cycle N+1, with add_a/add_b registered from the granted requester's operands.
REQ-010 A tag pipeline of ADD_LAT stages holding {valid, id} SHALL track each issue; in cycle N+1+ADD_LAT the block SHALL push {id, add_res, add_ovf} into the FIFO.
REQ-011 The FIFO SHALL present its head on rsp_valid/rsp_id/rsp_res/rsp_ovf from registers; a push into an empty FIFO SHALL produce rsp_valid=1 in cycle N+2+ADD_LAT.
REQ-012 A pop SHALL occur when rsp_valid and rsp_ready are both 1; a simultaneous push and pop SHALL keep the FIFO count unchanged and preserve order.
REQ-013 The credit mechanism SHALL make FIFO overflow impossible; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-014 When the adder is unused, add_a/add_b SHALL hold their last values and add_valid SHALL be 0.
REQ-015 busy SHALL equal (cnt != 0).

Reset
REQ-016 While rst_n is 0, the block SHALL force req_ready=0, add_valid=0, add_a=0, add_b=0, rsp_valid=0, rsp_id=0, rsp_res=0, rsp_ovf=0, busy=0, cnt=0, FIFO empty, all tag-pipeline valids cleared, and RR pointer=0.
REQ-017 A reset asserted mid-operation SHALL discard all in-flight and queued operations, and any late add_res SHALL be ignored.

Configuration
REQ-018 With macro FPADD_ARBITER_SUB_EN defined, the block SHALL add input req_sub[NUM_REQ-1:0], and a granted request with req_sub[i]=1 SHALL issue add_b with bit 15 inverted (A-B).
REQ-019 Without FPADD_ARBITER_SUB_EN, port req_sub SHALL be absent and add_b SHALL be req_b passed unmodified.

Verification
REQ-020 Single request: req 0 sends A=0x3C00, B=0x4000, the adder model returns 0x4200, rsp_ready=1 -> handshake at N, add_valid at N+1, rsp_valid at N+5 (ADD_LAT=3) with rsp_id=0, rsp_res=0x4200.
REQ-021 All four requesters hold valid continuously after reset -> grant order 0,1,2,3,0, and rsp_id follows the same sequence.
REQ-022 rsp_ready held 0 with all requesters valid -> exactly 4 grants, then req_ready=0 and busy=1; one pop -> exactly one new grant in the following cycle.
REQ-023 rsp_ready=1 with back-to-back issues -> one response per cycle in order, FIFO count stable, no loss across pointer wrap after 20 operations.
REQ-024 rst_n pulsed low with 2 operations in flight -> all outputs 0 immediately, no rsp_valid afterwards, and the next grant goes to requester 0.
REQ-025 With FPADD_ARBITER_SUB_EN defined: req 1 sends A=0x4200, B=0x3C00, req_sub[1]=1 -> add_b=0xBC00 on the add_valid cycle.
